// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and counter widths for the fetch/data bus arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    localparam int BURST_CNT_W   = 8;
    localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - loadable down-counter flagging a bus cycle that never acked
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int W = TIMEOUT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A load value of zero never reaches one, which is how the timeout is disabled.
    assign o_expired = i_en & (r_cnt == W'(1));

endmodule

// File: rtl/wb_core_bus_arbiter.sv
// rtl/wb_core_bus_arbiter.sv - shares one Wishbone master between fetch and data requesters
module wb_core_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_ack_o,
    output logic                  i_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ack_o,
    output logic                  d_err_o,
    output logic                  hold_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i
);

    localparam logic [BURST_CNT_W-1:0]   L_MAX_BURST = BURST_CNT_W'(MAX_DATA_BURST);
    localparam logic [TIMEOUT_CNT_W-1:0] L_TIMEOUT   = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

    arb_state_t              r_state;
    arb_state_t              r_state_next;
    logic [BURST_CNT_W-1:0]  r_burst;
    logic                    r_cyc;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_i_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic                    r_i_ack;
    logic                    r_d_ack;
    logic                    r_i_err;
    logic                    r_d_err;

    logic                    w_can_grant;
    logic                    w_data_wins;
    logic                    w_gnt_data;
    logic                    w_gnt_instr;
    logic                    w_expired;
    logic                    w_done;

    // Requests are still high during their own ack pulse, so no grant is made in that cycle.
    assign w_can_grant = (r_state == ARB_IDLE) & ~r_i_ack & ~r_d_ack;
    assign w_data_wins = d_req_i & ((r_burst < L_MAX_BURST) | ~i_req_i);
    assign w_gnt_data  = w_can_grant & w_data_wins;
    assign w_gnt_instr = w_can_grant & i_req_i & ~w_data_wins;
    assign w_done      = r_cyc & (wb_ack_i | w_expired);

    wb_arb_timeout #(
        .W(TIMEOUT_CNT_W)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_done),
        .i_load     (w_gnt_data | w_gnt_instr),
        .i_load_val (L_TIMEOUT),
        .i_en       (r_cyc),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_gnt_data) begin
                    r_state_next = ARB_DATA;
                end else if (w_gnt_instr) begin
                    r_state_next = ARB_INSTR;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (w_done) begin
                    r_state_next = ARB_IDLE;
                end
            end
            default: r_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
            if (w_gnt_data) begin
                r_cyc   <= 1'b1;
                r_we    <= d_we_i;
                r_addr  <= d_addr_i;
                r_wdata <= d_wdata_i;
            end else if (w_gnt_instr) begin
                r_cyc   <= 1'b1;
                r_we    <= 1'b0;
                r_addr  <= i_addr_i;
                r_wdata <= '0;
            end else if (w_done) begin
                // A real ack on the expiry edge wins over the timeout.
                r_cyc <= 1'b0;
                if (r_state == ARB_DATA) begin
                    r_d_ack   <= 1'b1;
                    r_d_err   <= ~wb_ack_i;
                    r_d_rdata <= wb_ack_i ? wb_data_i : '0;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_err   <= ~wb_ack_i;
                    r_i_rdata <= wb_ack_i ? wb_data_i : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= '0;
        end else if (!i_req_i || w_gnt_instr) begin
            r_burst <= '0;
        end else if (w_gnt_data && (r_burst < L_MAX_BURST)) begin
            r_burst <= r_burst + 1'b1;
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_data_o = r_wdata;
    assign i_rdata_o = r_i_rdata;
    assign i_ack_o   = r_i_ack;
    assign i_err_o   = r_i_err;
    assign d_rdata_o = r_d_rdata;
    assign d_ack_o   = r_d_ack;
    assign d_err_o   = r_d_err;
    assign hold_o    = rst_n & ((i_req_i & ~r_i_ack) | (d_req_i & ~r_d_ack));

endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// tb/tb_wb_core_bus_arbiter.sv - directed scoreboard bench for wb_core_bus_arbiter
module tb_wb_core_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic [31:0] i_rdata_o;
    logic        i_ack_o;
    logic        i_err_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic        hold_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   slave_wait = 0;
    logic slave_stray = 1'b0;
    int   s_cnt = 0;
    logic prev_cyc = 1'b0;

    wb_core_bus_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_DATA_BURST (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_rdata_o (i_rdata_o),
        .i_ack_o   (i_ack_o),
        .i_err_o   (i_err_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_rdata_o (d_rdata_o),
        .d_ack_o   (d_ack_o),
        .d_err_o   (d_err_o),
        .hold_o    (hold_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_addr_o (wb_addr_o),
        .wb_data_o (wb_data_o),
        .wb_data_i (wb_data_i),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave: acks once cyc has been high for more than slave_wait cycles; negative never acks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (slave_stray) begin
                wb_ack_i  = 1'b1;
                wb_data_i = 32'hBAD0BAD0;
                s_cnt     = 0;
            end else if (wb_cyc_o) begin
                s_cnt++;
                wb_ack_i  = (slave_wait >= 0) && (s_cnt > slave_wait);
                wb_data_i = wb_ack_i ? rdata_of(wb_addr_o) : 32'h0;
            end else begin
                s_cnt     = 0;
                wb_ack_i  = 1'b0;
                wb_data_i = 32'h0;
            end
        end
    end

    initial begin
        bus_t b;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("stb_eq_cyc", {31'h0, wb_stb_o}, {31'h0, wb_cyc_o});
                if (wb_cyc_o && !prev_cyc) begin
                    chk("grant_expected", (exp_bus.size() > 0) ? 32'h1 : 32'h0, 32'h1);
                    if (exp_bus.size() > 0) begin
                        b = exp_bus.pop_front();
                        chk("grant_we", {31'h0, wb_we_o}, {31'h0, b.we});
                        chk("grant_addr", wb_addr_o, b.addr);
                        chk("grant_wdata", wb_data_o, b.wdata);
                    end
                end
                if (i_ack_o || d_ack_o) begin
                    chk("rsp_expected", (exp_rsp.size() > 0) ? 32'h1 : 32'h0, 32'h1);
                    if (exp_rsp.size() > 0) begin
                        r = exp_rsp.pop_front();
                        chk("rsp_port", {31'h0, d_ack_o}, {31'h0, r.is_data});
                        chk("rsp_rdata", d_ack_o ? d_rdata_o : i_rdata_o, r.rdata);
                        chk("rsp_err", {31'h0, d_ack_o ? d_err_o : i_err_o}, {31'h0, r.err});
                    end
                end
            end
            prev_cyc = wb_cyc_o;
        end
    end

    initial begin
        int lat;
        int n_d;
        int ncyc;
        logic got;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_iack", {31'h0, i_ack_o}, 32'h0);
        chk("rst_dack", {31'h0, d_ack_o}, 32'h0);
        chk("rst_hold", {31'h0, hold_o}, 32'h0);
        chk("rst_addr", wb_addr_o, 32'h0);
        rst_n = 1'b1;

        // Fetch only, slave waits one cycle.
        slave_wait = 1;
        exp_bus.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_rsp.push_back('{is_data: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
        i_addr_i = 32'h100;
        i_req_i  = 1'b1;
        #1;
        chk("hold_on_req", {31'h0, hold_o}, 32'h1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (i_ack_o) begin
                lat = k;
                chk("hold_in_ack", {31'h0, hold_o}, 32'h0);
                i_req_i = 1'b0;
            end else begin
                chk("hold_pending", {31'h0, hold_o}, 32'h1);
            end
        end
        chk("fetch_latency", lat, 3);
        step();
        chk("iack_one_cycle", {31'h0, i_ack_o}, 32'h0);
        chk("hold_idle", {31'h0, hold_o}, 32'h0);

        // Simultaneous requests: data write first, then the fetch.
        slave_wait = 0;
        exp_bus.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'h12345678});
        exp_bus.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
        exp_rsp.push_back('{is_data: 1'b1, rdata: rdata_of(32'h2000), err: 1'b0});
        exp_rsp.push_back('{is_data: 1'b0, rdata: rdata_of(32'h300), err: 1'b0});
        d_we_i    = 1'b1;
        d_addr_i  = 32'h2000;
        d_wdata_i = 32'h12345678;
        i_addr_i  = 32'h300;
        i_req_i   = 1'b1;
        d_req_i   = 1'b1;
        for (int k = 0; k < 40 && (i_req_i || d_req_i); k++) begin
            step();
            if (d_ack_o) d_req_i = 1'b0;
            if (i_ack_o) i_req_i = 1'b0;
        end
        chk("t2_both_done", {30'h0, i_req_i, d_req_i}, 32'h0);
        step();

        // Continuous data reads with a waiting fetch.
        d_we_i    = 1'b0;
        d_wdata_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_bus.push_back('{we: 1'b0, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0});
            exp_rsp.push_back('{is_data: 1'b1, rdata: rdata_of(32'h3000 + 32'(4 * i)), err: 1'b0});
        end
        exp_bus.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
        exp_rsp.push_back('{is_data: 1'b0, rdata: rdata_of(32'h400), err: 1'b0});
        d_addr_i = 32'h3000;
        i_addr_i = 32'h400;
        d_req_i  = 1'b1;
        i_req_i  = 1'b1;
        n_d = 0;
        for (int k = 0; k < 80 && i_req_i; k++) begin
            step();
            if (d_ack_o) begin
                n_d++;
                d_addr_i = d_addr_i + 32'h4;
            end
            if (i_ack_o) begin
                i_req_i = 1'b0;
                d_req_i = 1'b0;
            end
        end
        chk("t3_data_before_fetch", n_d, 4);
        chk("t3_fetch_done", {31'h0, i_req_i}, 32'h0);
        repeat (5) step();
        chk("t3_quiet", {31'h0, wb_cyc_o}, 32'h0);

        // Timeout, then ack landing on the expiry edge.
        for (int t = 0; t < 2; t++) begin
            slave_wait = (t == 0) ? -1 : 7;
            d_addr_i   = (t == 0) ? 32'h5000 : 32'h5800;
            exp_bus.push_back('{we: 1'b0, addr: d_addr_i, wdata: 32'h0});
            exp_rsp.push_back('{is_data: 1'b1, rdata: (t == 0) ? 32'h0 : rdata_of(d_addr_i),
                                err: (t == 0) ? 1'b1 : 1'b0});
            d_req_i = 1'b1;
            ncyc = 0;
            got  = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                step();
                if (d_ack_o) begin
                    got     = 1'b1;
                    d_req_i = 1'b0;
                end else if (wb_cyc_o) begin
                    ncyc++;
                end
            end
            chk((t == 0) ? "t4_timeout_ack" : "t5_edge_ack", {31'h0, got}, 32'h1);
            chk((t == 0) ? "t4_cyc_cycles" : "t5_cyc_cycles", ncyc, 8);
            step();
        end

        // Reset while a write waits on a stuck slave; stray acks afterwards.
        slave_wait = -1;
        exp_bus.push_back('{we: 1'b1, addr: 32'h6000, wdata: 32'hCAFEF00D});
        d_we_i    = 1'b1;
        d_addr_i  = 32'h6000;
        d_wdata_i = 32'hCAFEF00D;
        d_req_i   = 1'b1;
        repeat (3) step();
        chk("t6_cyc_before_reset", {31'h0, wb_cyc_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("t6_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("t6_we", {31'h0, wb_we_o}, 32'h0);
        chk("t6_addr", wb_addr_o, 32'h0);
        chk("t6_wdata", wb_data_o, 32'h0);
        chk("t6_hold", {31'h0, hold_o}, 32'h0);
        chk("t6_drdata", d_rdata_o, 32'h0);
        chk("t6_irdata", i_rdata_o, 32'h0);
        chk("t6_acks", {28'h0, i_ack_o, d_ack_o, i_err_o, d_err_o}, 32'h0);
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_wdata_i   = 32'h0;
        slave_stray = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_ack", {30'h0, i_ack_o, d_ack_o}, 32'h0);
            chk("t6_idle_cyc", {31'h0, wb_cyc_o}, 32'h0);
        end
        slave_stray = 1'b0;

        repeat (3) step();
        chk("bus_queue_empty", exp_bus.size(), 32'h0);
        chk("rsp_queue_empty", exp_rsp.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
